// File: rtl/playback_scheduler.sv
// Transport controller: PS/2 SPACE/ESC drive IDLE/PLAY/PAUSE, tempo ticks advance the step and pass count.
// Every output is a register that updates on the edge that samples the key or tick; inputs are never stalled.
module playback_scheduler #(
  parameter int STEPS = 16,
  parameter int SW    = $clog2(STEPS)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [7:0]    data,
  input  logic          data_en,
  input  logic [6:0]    Loops,
  input  logic          step_tick,
  output logic [SW-1:0] step,
  output logic [6:0]    loop_count,
  output logic          playing,
  output logic          paused,
  output logic          edit_en,
  output logic          step_strobe,
  output logic          done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [6:0]    MAX_LOOPS = 7'd99;

  logic [1:0]    r_state;
  logic          r_brk;
  logic [6:0]    r_tgt;
  logic [SW-1:0] r_step;
  logic [6:0]    r_lc;
  logic          r_playing;
  logic          r_paused;
  logic          r_edit_en;
  logic          r_strobe;
  logic          r_done;

  logic          w_press;
  logic          w_space;
  logic          w_esc;
  logic [6:0]    w_loops_clamped;
  logic [6:0]    w_lc_inc;
  logic [1:0]    w_state_nx;
  logic [6:0]    w_tgt_nx;
  logic [SW-1:0] w_step_nx;
  logic [6:0]    w_lc_nx;
  logic          w_strobe_nx;
  logic          w_done_nx;

  // The byte after F0 is a release code; E0 is only a prefix and never consumes the break.
  assign w_press         = data_en && !r_brk && (data != KEY_BRK) && (data != KEY_EXT);
  assign w_space         = w_press && (data == KEY_SPACE);
  assign w_esc           = w_press && (data == KEY_ESC);
  assign w_loops_clamped = (Loops > MAX_LOOPS) ? MAX_LOOPS : Loops;
  assign w_lc_inc        = r_lc + 7'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_tgt_nx    = r_tgt;
    w_step_nx   = r_step;
    w_lc_nx     = r_lc;
    w_strobe_nx = 1'b0;
    w_done_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_space) begin
          w_state_nx  = ST_PLAY;
          w_tgt_nx    = w_loops_clamped;
          w_step_nx   = '0;
          w_lc_nx     = '0;
          w_strobe_nx = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_space) begin
          w_state_nx = ST_PAUSE;
        end else if (w_esc) begin
          w_state_nx = ST_IDLE;
          w_step_nx  = '0;
          w_lc_nx    = '0;
        end else if (step_tick) begin
          if (r_step != LAST_STEP) begin
            w_step_nx   = r_step + SW'(1);
            w_strobe_nx = 1'b1;
          end else if ((r_tgt != 7'd0) && (w_lc_inc == r_tgt)) begin
            w_state_nx = ST_IDLE;
            w_step_nx  = '0;
            w_lc_nx    = r_tgt;
            w_done_nx  = 1'b1;
          end else begin
            // Endless runs count passes modulo 100 to stay within the display range.
            w_step_nx   = '0;
            w_lc_nx     = ((r_tgt == 7'd0) && (r_lc == MAX_LOOPS)) ? 7'd0 : w_lc_inc;
            w_strobe_nx = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (w_space) begin
          w_state_nx = ST_PLAY;
        end else if (w_esc) begin
          w_state_nx = ST_IDLE;
          w_step_nx  = '0;
          w_lc_nx    = '0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_step_nx  = '0;
        w_lc_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_brk     <= 1'b0;
      r_tgt     <= '0;
      r_step    <= '0;
      r_lc      <= '0;
      r_playing <= 1'b0;
      r_paused  <= 1'b0;
      r_edit_en <= 1'b1;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (data_en) begin
        if (data == KEY_BRK)
          r_brk <= 1'b1;
        else if (data != KEY_EXT)
          r_brk <= 1'b0;
      end
      r_state   <= w_state_nx;
      r_tgt     <= w_tgt_nx;
      r_step    <= w_step_nx;
      r_lc      <= w_lc_nx;
      r_playing <= (w_state_nx == ST_PLAY);
      r_paused  <= (w_state_nx == ST_PAUSE);
      r_edit_en <= (w_state_nx == ST_IDLE);
      r_strobe  <= w_strobe_nx;
      r_done    <= w_done_nx;
    end
  end

  assign step        = r_step;
  assign loop_count  = r_lc;
  assign playing     = r_playing;
  assign paused      = r_paused;
  assign edit_en     = r_edit_en;
  assign step_strobe = r_strobe;
  assign done        = r_done;

endmodule

// File: tb/tb_playback_scheduler.sv
// Bench for playback_scheduler: key-filter vector table plus hand-built run sequences.
// Expected output words are queued as each cycle is driven and compared once the edge has landed.
module tb_playback_scheduler;

  logic       Clock;
  logic       nReset;
  logic [7:0] data;
  logic       data_en;
  logic [6:0] Loops;
  logic       step_tick;
  logic [3:0] step;
  logic [6:0] loop_count;
  logic       playing;
  logic       paused;
  logic       edit_en;
  logic       step_strobe;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        den;
    logic [7:0]  dat;
    logic        tick;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[18];

  playback_scheduler #(.STEPS(16), .SW(4)) dut (
    .Clock(Clock), .nReset(nReset), .data(data), .data_en(data_en),
    .Loops(Loops), .step_tick(step_tick), .step(step), .loop_count(loop_count),
    .playing(playing), .paused(paused), .edit_en(edit_en),
    .step_strobe(step_strobe), .done(done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Output word: {step, loop_count, playing, paused, edit_en, step_strobe, done}
  function automatic logic [15:0] ew(int st, int lc, bit pl, bit pa, bit ed, bit sb, bit dn);
    logic [3:0] s4;
    logic [6:0] l7;
    s4 = st[3:0];
    l7 = lc[6:0];
    return {s4, l7, pl, pa, ed, sb, dn};
  endfunction

  function automatic logic [15:0] pl_w(int st, int lc, bit sb);
    return ew(st, lc, 1, 0, 0, sb, 0);
  endfunction

  function automatic logic [15:0] pa_w(int st, int lc);
    return ew(st, lc, 0, 1, 0, 0, 0);
  endfunction

  function automatic logic [15:0] id_w(int lc, bit dn);
    return ew(0, lc, 0, 0, 1, 0, dn);
  endfunction

  task automatic check_out();
    logic [15:0] got;
    logic [15:0] e;
    string nm;
    got = {step, loop_count, playing, paused, edit_en, step_strobe, done};
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got step=%0d lc=%0d pl=%b pa=%b ed=%b sb=%b dn=%b, want step=%0d lc=%0d pl=%b pa=%b ed=%b sb=%b dn=%b",
               nm, got[15:12], got[11:5], got[4], got[3], got[2], got[1], got[0],
               e[15:12], e[11:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  task automatic expect_now(input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    check_out();
  endtask

  task automatic cmp_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // One clock cycle of stimulus; called at a negedge and returns at the next negedge.
  task automatic apply(input logic den, input logic [7:0] dat, input logic tick,
                       input logic [15:0] e, input string nm);
    data_en   = den;
    data      = dat;
    step_tick = tick;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clock);
    #1;
    check_out();
    @(negedge Clock);
    data_en   = 1'b0;
    step_tick = 1'b0;
  endtask

  task automatic key(input logic [7:0] k, input logic [15:0] e, input string nm);
    apply(1'b1, k, 1'b0, e, nm);
  endtask

  task automatic tick(input logic [15:0] e, input string nm);
    apply(1'b0, 8'h00, 1'b1, e, nm);
  endtask

  task automatic set_vec(input int i, input logic den, input logic [7:0] dat,
                         input logic tk, input logic [15:0] e);
    tbl[i].den  = den;
    tbl[i].dat  = dat;
    tbl[i].tick = tk;
    tbl[i].exp  = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    nReset    = 1'b0;
    data      = 8'h00;
    data_en   = 1'b0;
    Loops     = 7'd2;
    step_tick = 1'b0;
    #12;
    expect_now(id_w(0, 0), "reset_state");
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);

    // Key filter and basic transport, Loops=2
    set_vec(0,  1, 8'hF0, 0, id_w(0, 0));
    set_vec(1,  1, 8'h29, 0, id_w(0, 0));
    set_vec(2,  1, 8'h29, 0, pl_w(0, 0, 1));
    set_vec(3,  0, 8'h00, 0, pl_w(0, 0, 0));
    set_vec(4,  0, 8'h00, 1, pl_w(1, 0, 1));
    set_vec(5,  1, 8'hE0, 0, pl_w(1, 0, 0));
    set_vec(6,  1, 8'hF0, 0, pl_w(1, 0, 0));
    set_vec(7,  1, 8'h76, 0, pl_w(1, 0, 0));
    set_vec(8,  1, 8'h29, 0, pa_w(1, 0));
    set_vec(9,  0, 8'h00, 1, pa_w(1, 0));
    set_vec(10, 1, 8'hF0, 0, pa_w(1, 0));
    set_vec(11, 1, 8'h29, 0, pa_w(1, 0));
    set_vec(12, 1, 8'hE0, 0, pa_w(1, 0));
    set_vec(13, 1, 8'h29, 0, pl_w(1, 0, 0));
    set_vec(14, 0, 8'h00, 1, pl_w(2, 0, 1));
    set_vec(15, 1, 8'h76, 0, id_w(0, 0));
    set_vec(16, 1, 8'h76, 0, id_w(0, 0));
    set_vec(17, 0, 8'h00, 1, id_w(0, 0));
    for (int i = 0; i < 18; i++)
      apply(tbl[i].den, tbl[i].dat, tbl[i].tick, tbl[i].exp, $sformatf("tbl[%0d]", i));

    // Finite run of two passes; Loops changed mid-run must not matter
    Loops = 7'd2;
    key(8'h29, pl_w(0, 0, 1), "run2_start");
    strobes = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 8) Loops = 7'd5;
      if (k == 32) tick(id_w(2, 1), "run2_done");
      else tick(pl_w(k % 16, k / 16, 1), $sformatf("run2_tick%0d", k));
      strobes += int'(step_strobe);
    end
    cmp_int("run2_strobes", strobes, 31);
    apply(0, 8'h00, 0, id_w(2, 0), "run2_hold");

    // Pause / resume
    Loops = 7'd0;
    key(8'h29, pl_w(0, 0, 1), "pr_start");
    for (int k = 1; k <= 5; k++) tick(pl_w(k, 0, 1), $sformatf("pr_tick%0d", k));
    key(8'h29, pa_w(5, 0), "pr_pause");
    for (int k = 0; k < 3; k++) tick(pa_w(5, 0), $sformatf("pr_ptick%0d", k));
    key(8'h29, pl_w(5, 0, 0), "pr_resume");
    tick(pl_w(6, 0, 1), "pr_tick6");
    key(8'h76, id_w(0, 0), "pr_esc");

    // Endless run: 100 passes wrap loop_count back to 0
    key(8'h29, pl_w(0, 0, 1), "inf_start");
    for (int k = 1; k <= 1600; k++)
      tick(pl_w(k % 16, (k / 16) % 100, 1), $sformatf("inf_tick%0d", k));
    key(8'h76, id_w(0, 0), "inf_esc");

    // Loops above 99 behaves as 99
    Loops = 7'd120;
    key(8'h29, pl_w(0, 0, 1), "clamp_start");
    for (int k = 1; k <= 1584; k++) begin
      if (k == 1584) tick(id_w(99, 1), "clamp_done");
      else tick(pl_w(k % 16, k / 16, 1), $sformatf("clamp_tick%0d", k));
    end

    // Key beats tick, then reset mid-play
    Loops = 7'd0;
    key(8'h29, pl_w(0, 0, 1), "kt_start");
    for (int k = 1; k <= 3; k++) tick(pl_w(k, 0, 1), $sformatf("kt_tick%0d", k));
    apply(1, 8'h29, 1, pa_w(3, 0), "kt_same_cycle");
    key(8'h29, pl_w(3, 0, 0), "kt_resume");
    tick(pl_w(4, 0, 1), "kt_tick4");
    key(8'hF0, pl_w(4, 0, 0), "kt_brk");
    #2;
    nReset = 1'b0;
    #1;
    expect_now(id_w(0, 0), "rst_async");
    @(negedge Clock);
    expect_now(id_w(0, 0), "rst_held");
    nReset = 1'b1;
    @(negedge Clock);
    key(8'h29, pl_w(0, 0, 1), "rst_brk_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
